crc_frame_engine: RTL and testbench

Parametrised successor to the single-frame CRC output controller. Walks a block of NUM_WORDS RAM words and runs one of two modes:
- Generate mode: computes a CRC_LEN-bit CRC per word by bit-serial long division, then writes the word back tagged first/middle/last.
- Check mode: recomputes each CRC and counts mismatches without writing.
After a successful generate pass it drives the output-enable window for the downstream serialiser.

---
 rtl/crc_frame_engine_pkg.sv | 22 ++
 rtl/crc_frame_engine_if.sv | 34 +++
 rtl/crc_serial_div.sv | 26 ++
 rtl/crc_frame_engine.sv | 177 +++++++++++++++++
 tb/tb_crc_frame_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_engine_pkg.sv
// Shared types, tag encodings and width helper for the CRC frame engine.
package crc_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_WRITE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b10;
  localparam logic [1:0] TAG_LAST  = 2'b11;

  // RAM word = {tag[1:0], message, crc}
  function automatic int data_w(input int mess_len, input int crc_len);
    return mess_len + crc_len + 2;
  endfunction

endpackage

// File: rtl/crc_frame_engine_if.sv
// Control, RAM and serialiser-enable bundle between the engine and its host.
interface crc_frame_engine_if
  import crc_frame_pkg::*;
#(
  parameter int MESS_LEN = 10,
  parameter int CRC_LEN  = 4,
  parameter int ADDR_W   = 5
);
  localparam int DATA_W = data_w(MESS_LEN, CRC_LEN);

  logic              start;
  logic              check_mode;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] address;
  logic              wren;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   err_count;
  logic              data_oe;
  logic              clk_oe;

  // engine side
  modport master (
    input  start, check_mode, q,
    output address, wren, data_out, busy, done, err_count, data_oe, clk_oe
  );

  // host / RAM side
  modport slave (
    output start, check_mode, q,
    input  address, wren, data_out, busy, done, err_count, data_oe, clk_oe
  );
endinterface

// File: rtl/crc_serial_div.sv
// Bit-serial CRC long divider, one message bit per enabled cycle, MSB first.
// Also instantiated by the receiver-side checker.
module crc_serial_div #(
  parameter int                CRC_LEN = 4,
  parameter logic [CRC_LEN:0]  POLY    = 5'b10011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [CRC_LEN-1:0] rem
);
  logic fb;

  assign fb = rem[CRC_LEN-1] ^ bit_in;

  // shift-and-subtract step; clr restarts the division for a new word
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rem <= '0;
    end else if (en) begin
      rem <= {rem[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY[CRC_LEN-1:0] : '0);
    end
  end
endmodule

// File: rtl/crc_frame_engine.sv
// Walks a RAM block: generate mode tags and writes back CRC'd words then opens
// the serialiser window; check mode recomputes CRCs and counts mismatches.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | address held RD_LAT cycles, word latched from q on the last one
// CALC   | MESS_LEN division steps through crc_serial_div
// WRITE  | write-back (generate) or CRC compare (check), then next word
// STREAM | serialiser enables high while the block addresses are replayed
// DONE   | one-cycle done pulse
module crc_frame_engine
  import crc_frame_pkg::*;
#(
  parameter int               MESS_LEN    = 10,
  parameter int               CRC_LEN     = 4,
  parameter logic [CRC_LEN:0] POLY        = 5'b10011,
  parameter int               NUM_WORDS   = 14,
  parameter int               ADDR_W      = 5,
  parameter int               BASE_ADDR   = 0,
  parameter int               RD_LAT      = 2,
  parameter int               TAIL_CYCLES = 30
) (
  input  logic               clk,
  input  logic               rst,
  crc_frame_engine_if.master bus
);
  localparam int DATA_W = data_w(MESS_LEN, CRC_LEN);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam int BIT_W  = $clog2(MESS_LEN + 1);
  localparam int STR_W  = $clog2(NUM_WORDS + TAIL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);

  if (CRC_LEN < 2) begin : g_bad_crc_len
    $error("crc_frame_engine: CRC_LEN must be at least 2");
  end
  if (POLY[CRC_LEN] != 1'b1) begin : g_bad_poly
    $error("crc_frame_engine: POLY MSB must be 1");
  end
  if (NUM_WORDS < 1 || RD_LAT < 1) begin : g_bad_counts
    $error("crc_frame_engine: NUM_WORDS and RD_LAT must be at least 1");
  end
  if (BASE_ADDR + NUM_WORDS - 1 >= 2 ** ADDR_W) begin : g_bad_addr
    $error("crc_frame_engine: block does not fit in ADDR_W address bits");
  end

  state_t              state;
  logic                mode;
  logic [LAT_W-1:0]    lat_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [STR_W-1:0]    str_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [MESS_LEN-1:0] msg;
  logic [MESS_LEN-1:0] msg_sh;
  logic [CRC_LEN-1:0]  rx_crc;
  logic [CRC_LEN-1:0]  rem;
  logic [1:0]          tag;
  logic                last_word;

  // last takes precedence so a one-word block is tagged last
  assign last_word = (word_idx == LAST_IDX);
  assign tag       = last_word ? TAG_LAST : (word_idx == '0) ? TAG_FIRST : TAG_MID;

  // rem only settles at the CALC->WRITE edge, so the write word is assembled
  // from registers and gated by the registered wren
  assign bus.data_out = bus.wren ? DATA_W'({tag, msg, rem}) : '0;

  crc_serial_div #(
    .CRC_LEN (CRC_LEN),
    .POLY    (POLY)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_FETCH),
    .en     (state == ST_CALC),
    .bit_in (msg_sh[MESS_LEN-1]),
    .rem    (rem)
  );

  // pass sequencer with registered RAM and serialiser controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode          <= 1'b0;
      lat_cnt       <= '0;
      bit_cnt       <= '0;
      str_cnt       <= '0;
      word_idx      <= '0;
      msg           <= '0;
      msg_sh        <= '0;
      rx_crc        <= '0;
      bus.address   <= FIRST_ADDR;
      bus.wren      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err_count <= '0;
      bus.data_oe   <= 1'b0;
      bus.clk_oe    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode          <= bus.check_mode;
            bus.address   <= FIRST_ADDR;
            word_idx      <= '0;
            bus.err_count <= '0;
            bus.busy      <= 1'b1;
            lat_cnt       <= LAT_W'(RD_LAT - 1);
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (lat_cnt == '0) begin
            msg     <= bus.q[MESS_LEN+CRC_LEN-1:CRC_LEN];
            msg_sh  <= bus.q[MESS_LEN+CRC_LEN-1:CRC_LEN];
            rx_crc  <= bus.q[CRC_LEN-1:0];
            bit_cnt <= BIT_W'(MESS_LEN - 1);
            state   <= ST_CALC;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_CALC: begin
          msg_sh <= {msg_sh[MESS_LEN-2:0], 1'b0};
          if (bit_cnt == '0) begin
            bus.wren <= ~mode;
            state    <= ST_WRITE;
          end else begin
            bit_cnt <= bit_cnt - BIT_W'(1);
          end
        end
        ST_WRITE: begin
          bus.wren <= 1'b0;
          if (mode) begin
            bus.err_count <= bus.err_count + (ADDR_W + 1)'(rem != rx_crc);
          end
          if (!last_word) begin
            bus.address <= bus.address + ADDR_W'(1);
            word_idx    <= word_idx + ADDR_W'(1);
            lat_cnt     <= LAT_W'(RD_LAT - 1);
            state       <= ST_FETCH;
          end else if (mode) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            bus.address <= FIRST_ADDR;
            str_cnt     <= STR_W'(NUM_WORDS + TAIL_CYCLES - 1);
            bus.data_oe <= 1'b1;
            bus.clk_oe  <= 1'b1;
            state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (bus.address != LAST_ADDR) begin
            bus.address <= bus.address + ADDR_W'(1);
          end
          if (str_cnt == '0) begin
            bus.data_oe <= 1'b0;
            bus.clk_oe  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= ST_DONE;
          end else begin
            str_cnt <= str_cnt - STR_W'(1);
          end
        end
        ST_DONE: begin
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench: default 14-word engine, a one-word engine and a CRC-8 engine,
// each with a small RAM model; expectations come from a long-division model
// and hand-computed constants.
`timescale 1ns/1ps
module tb_crc_frame_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  crc_frame_engine_if #(.MESS_LEN(10), .CRC_LEN(4), .ADDR_W(5)) bus_m ();
  crc_frame_engine_if #(.MESS_LEN(10), .CRC_LEN(4), .ADDR_W(5)) bus_1 ();
  crc_frame_engine_if #(.MESS_LEN(16), .CRC_LEN(8), .ADDR_W(5)) bus_w ();

  crc_frame_engine u_main (.clk(clk), .rst(rst), .bus(bus_m));
  crc_frame_engine #(.NUM_WORDS(1)) u_one (.clk(clk), .rst(rst), .bus(bus_1));
  crc_frame_engine #(.MESS_LEN(16), .CRC_LEN(8), .POLY(9'h107), .NUM_WORDS(1))
    u_wide (.clk(clk), .rst(rst), .bus(bus_w));

  // RAM models: q settles within RD_LAT (=2) cycles of the address
  logic [15:0] mem_m [32];
  logic [15:0] mem_1 [32];
  logic [25:0] mem_w [32];

  always @(posedge clk) begin
    if (bus_m.wren) mem_m[bus_m.address] <= bus_m.data_out;
    if (bus_1.wren) mem_1[bus_1.address] <= bus_1.data_out;
    if (bus_w.wren) mem_w[bus_w.address] <= bus_w.data_out;
    bus_m.q <= mem_m[bus_m.address];
    bus_1.q <= mem_1[bus_1.address];
    bus_w.q <= mem_w[bus_w.address];
  end

  // observation log, sampled 2 ns after each rising edge
  int          wr_m = 0, done_m = 0, oe_m = 0, oe_diff = 0;
  logic [4:0]  wa_m [256];
  logic [15:0] wd_m [256];
  logic [4:0]  oa_m [512];
  int          wr_1 = 0, done_1 = 0, oe_1 = 0;
  logic [15:0] wd_1;
  int          wr_w = 0, done_w = 0;
  logic [25:0] wd_w;

  always @(posedge clk) begin
    #2;
    if (bus_m.wren) begin
      wa_m[wr_m & 255] = bus_m.address;
      wd_m[wr_m & 255] = bus_m.data_out;
      wr_m++;
    end
    if (bus_m.done) done_m++;
    if (bus_m.data_oe) begin
      oa_m[oe_m & 511] = bus_m.address;
      oe_m++;
    end
    if (bus_1.wren) begin
      wd_1 = bus_1.data_out;
      wr_1++;
    end
    if (bus_1.done) done_1++;
    if (bus_1.data_oe) oe_1++;
    if (bus_w.wren) begin
      wd_w = bus_w.data_out;
      wr_w++;
    end
    if (bus_w.done) done_w++;
    if ((bus_m.data_oe != bus_m.clk_oe) || (bus_1.data_oe != bus_1.clk_oe) ||
        (bus_w.data_oe != bus_w.clk_oe)) oe_diff++;
  end

  // polynomial long division of msg*x^clen by poly
  function automatic logic [31:0] crc_ref(input logic [31:0] m, input int mlen,
                                         input int clen, input logic [32:0] poly);
    logic [63:0] a;
    a = {32'b0, m} << clen;
    for (int i = mlen + clen - 1; i >= clen; i--)
      if (a[i]) a = a ^ ({31'b0, poly} << (i - clen));
    return a[31:0] & ((32'd1 << clen) - 32'd1);
  endfunction

  function automatic logic [15:0] exp_word(input int i);
    logic [1:0]  t;
    logic [31:0] c;
    t = (i == 13) ? 2'b11 : (i == 0) ? 2'b01 : 2'b10;
    c = crc_ref(32'(i), 10, 4, 33'h13);
    return {t, i[9:0], c[3:0]};
  endfunction

  function automatic logic cur_done(input int which);
    case (which)
      0:       return bus_m.done;
      1:       return bus_1.done;
      default: return bus_w.done;
    endcase
  endfunction

  task automatic pulse_start(input int which, input logic mode);
    @(negedge clk);
    case (which)
      0:       begin bus_m.start = 1'b1; bus_m.check_mode = mode; end
      1:       begin bus_1.start = 1'b1; bus_1.check_mode = mode; end
      default: begin bus_w.start = 1'b1; bus_w.check_mode = mode; end
    endcase
    @(negedge clk);
    bus_m.start = 1'b0;
    bus_1.start = 1'b0;
    bus_w.start = 1'b0;
  endtask

  // cyc = 1 on the first cycle after the accepting edge
  task automatic wait_done(input int which, input int budget, output int cyc);
    cyc = 1;
    while (!cur_done(which) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_block();
    for (int a = 0; a < 32; a++) mem_m[a] = (a < 14) ? {2'b00, 10'(a), 4'b0000} : 16'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_m.address !== 5'd0) begin
      n_bad++; $display("FAIL reset_address: got %0d, want 0", bus_m.address);
    end
    n_cmp++;
    if ({bus_m.wren, bus_m.busy, bus_m.done, bus_m.data_oe, bus_m.clk_oe} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: wren/busy/done/data_oe/clk_oe got %b, want 00000",
        {bus_m.wren, bus_m.busy, bus_m.done, bus_m.data_oe, bus_m.clk_oe});
    end
    n_cmp++;
    if (bus_m.data_out !== 16'h0 || bus_m.err_count !== 6'd0) begin
      n_bad++; $display("FAIL reset_data: data_out %h err_count %0d, want 0 and 0",
        bus_m.data_out, bus_m.err_count);
    end
    n_cmp++;
    if ({bus_1.busy, bus_1.wren, bus_w.busy, bus_w.wren} !== 4'b0) begin
      n_bad++; $display("FAIL reset_others: busy/wren got %b, want 0000",
        {bus_1.busy, bus_1.wren, bus_w.busy, bus_w.wren});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int cyc, bw, bd, bo;
    logic [31:0] c;
    mem_1[0] = {2'b00, 10'b1101011011, 4'b0000};
    bw = wr_1; bd = done_1; bo = oe_1;
    pulse_start(1, 1'b0);
    wait_done(1, 80, cyc);
    @(negedge clk);
    n_cmp++;
    if (cyc !== 45) begin
      n_bad++; $display("FAIL single_latency: got %0d cycles, want 45", cyc);
    end
    n_cmp++;
    if (wr_1 - bw !== 1 || wd_1 !== 16'b11_1101011011_1110) begin
      n_bad++; $display("FAIL single_write: %0d writes data %b, want 1 write data %b",
        wr_1 - bw, wd_1, 16'b11_1101011011_1110);
    end
    c = crc_ref(32'b1101011011, 10, 4, 33'h13);
    n_cmp++;
    if (wd_1[3:0] !== c[3:0]) begin
      n_bad++; $display("FAIL single_crc_model: got %b, want %b", wd_1[3:0], c[3:0]);
    end
    n_cmp++;
    if (oe_1 - bo !== 31 || done_1 - bd !== 1) begin
      n_bad++; $display("FAIL single_stream: oe cycles %0d done pulses %0d, want 31 and 1",
        oe_1 - bo, done_1 - bd);
    end
  endtask

  task automatic test_generate_block();
    int cyc, bw, bd, bo, bad;
    load_block();
    bw = wr_m; bd = done_m; bo = oe_m;
    pulse_start(0, 1'b0);
    n_cmp++;
    if (bus_m.busy !== 1'b1) begin
      n_bad++; $display("FAIL gen_busy: got %b, want 1", bus_m.busy);
    end
    wait_done(0, 300, cyc);
    @(negedge clk);
    n_cmp++;
    if (cyc !== 227) begin
      n_bad++; $display("FAIL gen_latency: got %0d cycles, want 227", cyc);
    end
    n_cmp++;
    if (wr_m - bw !== 14) begin
      n_bad++; $display("FAIL gen_wren_cycles: got %0d, want 14", wr_m - bw);
    end
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (wa_m[bw+i] !== 5'(i) || wd_m[bw+i] !== exp_word(i)) begin
        n_bad++; $display("FAIL gen_word%0d: addr %0d data %h, want addr %0d data %h",
          i, wa_m[bw+i], wd_m[bw+i], i, exp_word(i));
      end
    end
    bad = 0;
    for (int k = 0; k < 44; k++) if (oa_m[bo+k] !== 5'((k < 14) ? k : 13)) bad++;
    n_cmp++;
    if (oe_m - bo !== 44 || bad !== 0 || oe_diff !== 0) begin
      n_bad++; $display("FAIL gen_stream: oe cycles %0d bad addrs %0d oe skew %0d, want 44 0 0",
        oe_m - bo, bad, oe_diff);
    end
    n_cmp++;
    if (done_m - bd !== 1 || bus_m.busy !== 1'b0) begin
      n_bad++; $display("FAIL gen_done: pulses %0d busy %b, want 1 and 0", done_m - bd, bus_m.busy);
    end
  endtask

  task automatic test_check_mode();
    int cyc, bw, bd, bo;
    mem_m[5] = mem_m[5] ^ 16'h0001;
    bw = wr_m; bd = done_m; bo = oe_m;
    pulse_start(0, 1'b1);
    wait_done(0, 300, cyc);
    @(negedge clk);
    n_cmp++;
    if (cyc !== 183) begin
      n_bad++; $display("FAIL chk_latency: got %0d cycles, want 183", cyc);
    end
    n_cmp++;
    if (wr_m - bw !== 0 || oe_m - bo !== 0 || done_m - bd !== 1) begin
      n_bad++; $display("FAIL chk_quiet: writes %0d oe %0d done %0d, want 0 0 1",
        wr_m - bw, oe_m - bo, done_m - bd);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus_m.err_count !== 6'd1) begin
      n_bad++; $display("FAIL chk_err_one: got %0d, want 1", bus_m.err_count);
    end
    mem_m[0]  = mem_m[0] ^ 16'h0004;
    mem_m[13] = mem_m[13] ^ 16'h0008;
    pulse_start(0, 1'b1);
    wait_done(0, 300, cyc);
    @(negedge clk);
    n_cmp++;
    if (bus_m.err_count !== 6'd3) begin
      n_bad++; $display("FAIL chk_err_three: got %0d, want 3", bus_m.err_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus_m.err_count !== 6'd0) begin
      n_bad++; $display("FAIL chk_err_rst: got %0d, want 0", bus_m.err_count);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bw, bd, bad;
    load_block();
    bw = wr_m;
    pulse_start(0, 1'b0);
    repeat (44) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_m.address !== 5'd0 || {bus_m.wren, bus_m.busy, bus_m.done, bus_m.data_oe} !== 4'b0 ||
        bus_m.data_out !== 16'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: addr %0d flags %b data %h, want 0 0000 0000",
        bus_m.address, {bus_m.wren, bus_m.busy, bus_m.done, bus_m.data_oe}, bus_m.data_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr_m - bw !== 3) begin
      n_bad++; $display("FAIL rst_mid_writes: got %0d, want 3", wr_m - bw);
    end
    bw = wr_m; bd = done_m;
    pulse_start(0, 1'b0);
    wait_done(0, 300, cyc);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 14; i++) if (wd_m[bw+i] !== exp_word(i) || wa_m[bw+i] !== 5'(i)) bad++;
    n_cmp++;
    if (cyc !== 227 || wr_m - bw !== 14 || bad !== 0 || done_m - bd !== 1) begin
      n_bad++; $display("FAIL rst_mid_rerun: cycles %0d writes %0d bad %0d done %0d, want 227 14 0 1",
        cyc, wr_m - bw, bad, done_m - bd);
    end
  endtask

  task automatic test_start_ignored();
    int bw, bd, bo;
    bw = wr_m; bd = done_m; bo = oe_m;
    pulse_start(0, 1'b0);
    bus_m.check_mode = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      bus_m.start = (c == 5 || c == 192 || c == 227);
      @(negedge clk);
    end
    bus_m.start = 1'b0;
    n_cmp++;
    if (done_m - bd !== 1 || bus_m.busy !== 1'b0) begin
      n_bad++; $display("FAIL ignore_done: pulses %0d busy %b, want 1 and 0", done_m - bd, bus_m.busy);
    end
    n_cmp++;
    if (wr_m - bw !== 14 || oe_m - bo !== 44 || wd_m[bw+13] !== exp_word(13)) begin
      n_bad++; $display("FAIL ignore_pass: writes %0d oe %0d last %h, want 14 44 %h",
        wr_m - bw, oe_m - bo, wd_m[bw+13], exp_word(13));
    end
  endtask

  task automatic test_wide_crc8();
    int cyc, bw, bd;
    logic [31:0] c;
    mem_w[0] = {2'b00, 16'h3132, 8'h00};
    bw = wr_w; bd = done_w;
    pulse_start(2, 1'b0);
    wait_done(2, 100, cyc);
    @(negedge clk);
    n_cmp++;
    if (cyc !== 51) begin
      n_bad++; $display("FAIL crc8_latency: got %0d cycles, want 51", cyc);
    end
    n_cmp++;
    if (wr_w - bw !== 1 || wd_w !== {2'b11, 16'h3132, 8'h72}) begin
      n_bad++; $display("FAIL crc8_word: %0d writes data %h, want 1 write data %h",
        wr_w - bw, wd_w, {2'b11, 16'h3132, 8'h72});
    end
    c = crc_ref(32'h3132, 16, 8, 33'h107);
    n_cmp++;
    if (wd_w[7:0] !== c[7:0] || done_w - bd !== 1) begin
      n_bad++; $display("FAIL crc8_model: crc %h done %0d, want %h and 1", wd_w[7:0], done_w - bd, c[7:0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_m.start = 1'b0; bus_m.check_mode = 1'b0;
    bus_1.start = 1'b0; bus_1.check_mode = 1'b0;
    bus_w.start = 1'b0; bus_w.check_mode = 1'b0;
    for (int a = 0; a < 32; a++) begin
      mem_m[a] = '0; mem_1[a] = '0; mem_w[a] = '0;
    end
    test_reset();
    test_single_word();
    test_generate_block();
    test_check_mode();
    test_reset_mid();
    test_start_ignored();
    test_wide_crc8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
